// File: rtl/key_command_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// key_command_scheduler_pkg
// Shared definitions for the keyboard command scheduler:
//   - PS/2 set-2 scan codes for the movement, control, prefix and arrow keys
//   - control-command encodings presented on ctrl_code
//   - byte-parser state encodings and the parser-to-scheduler event record
// Optional feature macro used by the files importing this package:
//   ARROW_KEYS_EN  (extended arrow keys alias the player-2 movement keys)
// ---------------------------------------------------------------------------
package key_command_scheduler_pkg;

   // movement keys
   localparam logic [7:0] SC_P1_LEFT     = 8'h1C;
   localparam logic [7:0] SC_P1_RIGHT    = 8'h23;
   localparam logic [7:0] SC_P2_LEFT     = 8'h3B;
   localparam logic [7:0] SC_P2_RIGHT    = 8'h4B;
   // control keys
   localparam logic [7:0] SC_ESC         = 8'h76;
   localparam logic [7:0] SC_SPACE       = 8'h29;
   localparam logic [7:0] SC_KEY_1       = 8'h16;
   localparam logic [7:0] SC_KEY_2       = 8'h1E;
   // prefixes
   localparam logic [7:0] SC_BREAK       = 8'hF0;
   localparam logic [7:0] SC_EXTEND      = 8'hE0;
   // extended (E0-prefixed) arrows
   localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
   localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      CTRL_ESC   = 2'b00,
      CTRL_SPACE = 2'b01,
      CTRL_KEY_1 = 2'b10,
      CTRL_KEY_2 = 2'b11
   } ctrl_code_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_BRK     = 2'b01,
      ST_EXT     = 2'b10,
      ST_EXT_BRK = 2'b11
   } parser_state_t;

   // One-cycle decoded key event from the parser.
   typedef struct packed {
      logic       make;
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } key_event_t;

   // Movement key index: 0 P1 left, 1 P1 right, 2 P2 left, 3 P2 right.
   function automatic logic [7:0] move_scan(input int idx);
      case (idx)
         0:       return SC_P1_LEFT;
         1:       return SC_P1_RIGHT;
         2:       return SC_P2_LEFT;
         default: return SC_P2_RIGHT;
      endcase
   endfunction

   // Control key index is also its priority rank: 0 ESC (highest) .. 3 KEY_2.
   function automatic logic [7:0] ctrl_scan(input int idx);
      case (idx)
         0:       return SC_ESC;
         1:       return SC_SPACE;
         2:       return SC_KEY_1;
         default: return SC_KEY_2;
      endcase
   endfunction

   function automatic ctrl_code_t ctrl_code_of(input int idx);
      case (idx)
         0:       return CTRL_ESC;
         1:       return CTRL_SPACE;
         2:       return CTRL_KEY_1;
         default: return CTRL_KEY_2;
      endcase
   endfunction

   // {right, left} match of an extended code against the arrow keys.
   function automatic logic [1:0] arrow_match(input logic [7:0] code);
      return {code == SC_ARROW_RIGHT, code == SC_ARROW_LEFT};
   endfunction

endpackage

// File: rtl/key_command_scheduler_ps2_code_parser.sv
// ---------------------------------------------------------------------------
// ps2_code_parser
// Detects each rising edge of the PS/2 byte-ready signal and walks the
// make / F0 break / E0 extended prefix sequence. For every byte that ends a
// sequence it emits a one-cycle event {make, brk, ext, code}.
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   done       byte-ready level/strobe; one byte per rising edge
//   tasta      received byte, valid when done rises
//   key_event  decoded event, valid for the capture cycle only
// ---------------------------------------------------------------------------
module ps2_code_parser
   import key_command_scheduler_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       done,
   input  logic [7:0] tasta,
   output key_event_t key_event
);

   logic          done_q_reg;
   parser_state_t state_reg;
   logic          capture;

   assign capture = done && !done_q_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done_q_reg <= 1'b0;
         state_reg  <= ST_IDLE;
      end else begin
         done_q_reg <= done;
         if (capture) begin
            case (state_reg)
               ST_IDLE: begin
                  if (tasta == SC_BREAK)       state_reg <= ST_BRK;
                  else if (tasta == SC_EXTEND) state_reg <= ST_EXT;
                  else                         state_reg <= ST_IDLE;
               end
               ST_EXT: begin
                  if (tasta == SC_BREAK) state_reg <= ST_EXT_BRK;
                  else                   state_reg <= ST_IDLE;
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   // The event is decoded in the capture cycle itself so the scheduler's
   // held map changes on the capture edge and is visible one cycle later.
   always_comb begin
      key_event      = '0;
      key_event.code = tasta;
      if (capture) begin
         case (state_reg)
            ST_IDLE: key_event.make = (tasta != SC_BREAK) && (tasta != SC_EXTEND);
            ST_BRK:  key_event.brk  = 1'b1;
            ST_EXT: begin
               key_event.make = (tasta != SC_BREAK);
               key_event.ext  = (tasta != SC_BREAK);
            end
            default: begin
               key_event.brk = 1'b1;
               key_event.ext = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_command_scheduler.sv
// ---------------------------------------------------------------------------
// key_command_scheduler
// Turns the PS/2 byte stream into per-frame paddle-move pulses (first delay
// then auto-repeat) and a prioritised valid/ack control-command channel.
// Optional feature: define ARROW_KEYS_EN to let the extended left/right
// arrows alias the player-2 left/right keys.
// Ports:
//   clock, reset           clock; asynchronous active-low reset
//   done, tasta            PS/2 byte strobe and byte
//   active_zone, x_pos,    VGA position; pixel (1,1) inside the visible
//   y_pos                  area marks the frame tick
//   p2_enable              0 suppresses player-2 moves
//   ctrl_ack               game FSM consumed the presented command
//   p1_left .. p2_right    one-clock move pulses, one clock after a tick
//   ctrl_valid, ctrl_code  pending control command (00 ESC .. 11 KEY_2)
//   held                   {p2_right, p2_left, p1_right, p1_left}
// ---------------------------------------------------------------------------
module key_command_scheduler
   import key_command_scheduler_pkg::*;
#(
   parameter int               CNT_W         = 6,
   parameter logic [CNT_W-1:0] FIRST_DELAY   = CNT_W'(8),
   parameter logic [CNT_W-1:0] REPEAT_FRAMES = CNT_W'(3)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       done,
   input  logic [7:0] tasta,
   input  logic       active_zone,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic       p2_enable,
   input  logic       ctrl_ack,
   output logic       p1_left,
   output logic       p1_right,
   output logic       p2_left,
   output logic       p2_right,
   output logic       ctrl_valid,
   output logic [1:0] ctrl_code,
   output logic [3:0] held
);

   localparam logic [CNT_W-1:0] FIRST_LOAD  = FIRST_DELAY - CNT_W'(1);
   localparam logic [CNT_W-1:0] REPEAT_LOAD = REPEAT_FRAMES - CNT_W'(1);

   key_event_t key_event;

   ps2_code_parser u_parser (
      .clock     (clock),
      .reset     (reset),
      .done      (done),
      .tasta     (tasta),
      .key_event (key_event)
   );

   // ---------------- frame tick ----------------
   logic tick_src;
   logic tick_src_q_reg;
   logic tick_reg;

   assign tick_src = active_zone && (x_pos == 10'd1) && (y_pos == 10'd1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_src_q_reg <= 1'b0;
         tick_reg       <= 1'b0;
      end else begin
         tick_src_q_reg <= tick_src;
         tick_reg       <= tick_src && !tick_src_q_reg;
      end
   end

   // ---------------- held map ----------------
   logic [3:0] move_held;    // plain (non-extended) movement keys
   logic [1:0] arrow_held;   // {right, left} arrows, zero when not built
   logic [3:0] held_map;

`ifdef ARROW_KEYS_EN
   logic [1:0] arrow_held_reg;
   logic [1:0] arrow_hit;

   assign arrow_hit = key_event.ext ? arrow_match(key_event.code) : 2'b00;

   // The arrow is a separate source: its break never clears the plain key.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         arrow_held_reg <= 2'b00;
      end else if (key_event.make) begin
         arrow_held_reg <= arrow_held_reg | arrow_hit;
      end else if (key_event.brk) begin
         arrow_held_reg <= arrow_held_reg & ~arrow_hit;
      end
   end

   assign arrow_held = arrow_held_reg;
`else
   assign arrow_held = 2'b00;
`endif

   assign held_map = {move_held[3] | arrow_held[1],
                      move_held[2] | arrow_held[0],
                      move_held[1:0]};
   assign held     = held_map;

   // ---------------- per-key move scheduling ----------------
   logic [3:0] move_pulse;

   for (genvar gi = 0; gi < 4; gi++) begin : g_move_key
      logic             hit;
      logic             held_bit_reg;
      logic             enabled;
      logic [CNT_W-1:0] cnt_reg;
      logic             first_reg;
      logic             pulse_reg;

      assign hit = !key_event.ext && (key_event.code == move_scan(gi));

      if (gi < 2) begin : g_p1
         assign enabled = 1'b1;
      end else begin : g_p2
         assign enabled = p2_enable;
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            held_bit_reg <= 1'b0;
         end else if (hit && key_event.make) begin
            held_bit_reg <= 1'b1;
         end else if (hit && key_event.brk) begin
            held_bit_reg <= 1'b0;
         end
      end

      // Scheduling reads held_map, i.e. the map as it stood before any byte
      // captured on this same edge.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt_reg   <= '0;
            first_reg <= 1'b1;
            pulse_reg <= 1'b0;
         end else begin
            pulse_reg <= 1'b0;
            if (tick_reg) begin
               if (!enabled || !held_map[gi]) begin
                  cnt_reg   <= '0;
                  first_reg <= 1'b1;
               end else if (held_map[gi ^ 1]) begin
                  // both directions held: this player's counters freeze
                  cnt_reg <= cnt_reg;
               end else if (cnt_reg == '0) begin
                  pulse_reg <= 1'b1;
                  cnt_reg   <= first_reg ? FIRST_LOAD : REPEAT_LOAD;
                  first_reg <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
         end
      end

      assign move_held[gi]  = held_bit_reg;
      assign move_pulse[gi] = pulse_reg;
   end

   assign p1_left  = move_pulse[0];
   assign p1_right = move_pulse[1];
   assign p2_left  = move_pulse[2];
   assign p2_right = move_pulse[3];

   // ---------------- control commands ----------------
   logic [3:0] ctrl_held_reg;
   logic [3:0] ctrl_pending_reg;
   logic [3:0] ctrl_make;
   logic [3:0] ctrl_brk;
   logic [3:0] ctrl_clr;
   logic [3:0] ctrl_sel_onehot;
   ctrl_code_t ctrl_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_ctrl_key
      logic hit;
      assign hit           = !key_event.ext && (key_event.code == ctrl_scan(gi));
      assign ctrl_make[gi] = hit && key_event.make;
      assign ctrl_brk[gi]  = hit && key_event.brk;
   end

   // Lowest index wins; the loop runs from lowest priority upwards.
   always_comb begin
      ctrl_sel        = CTRL_ESC;
      ctrl_sel_onehot = '0;
      for (int i = 3; i >= 0; i--) begin
         if (ctrl_pending_reg[i]) begin
            ctrl_sel        = ctrl_code_of(i);
            ctrl_sel_onehot = 4'b0001 << i;
         end
      end
   end

   assign ctrl_clr = (ctrl_ack && ctrl_valid) ? ctrl_sel_onehot : 4'b0000;

   // A fresh press (not a typematic repeat) sets pending; setting wins over
   // an ack of the same key in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_held_reg    <= 4'b0000;
         ctrl_pending_reg <= 4'b0000;
      end else begin
         ctrl_held_reg    <= (ctrl_held_reg | ctrl_make) & ~ctrl_brk;
         ctrl_pending_reg <= (ctrl_pending_reg & ~ctrl_clr) | (ctrl_make & ~ctrl_held_reg);
      end
   end

   assign ctrl_valid = |ctrl_pending_reg;
   assign ctrl_code  = ctrl_sel;

endmodule

// File: tb/tb_key_command_scheduler.sv
// ---------------------------------------------------------------------------
// tb_key_command_scheduler
// Drives PS/2 byte sequences and frame ticks into key_command_scheduler.
// Expected move pulses (tick number + pulse vector) and expected control
// codes are queued when stimulus is driven and compared when the DUT
// produces them.
// ---------------------------------------------------------------------------
module tb_key_command_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       done = 1'b0;
   logic [7:0] tasta = 8'h00;
   logic       active_zone = 1'b0;
   logic [9:0] x_pos = 10'd0;
   logic [9:0] y_pos = 10'd0;
   logic       p2_enable = 1'b1;
   logic       ctrl_ack = 1'b0;
   logic       p1_left, p1_right, p2_left, p2_right;
   logic       ctrl_valid;
   logic [1:0] ctrl_code;
   logic [3:0] held;

   int errors = 0;
   int checks = 0;
   int tick_no = 0;

   logic [35:0] move_q[$];   // {tick number, {p2r, p2l, p1r, p1l}}
   logic [1:0]  ctrl_q[$];   // control codes in expected presentation order

   key_command_scheduler dut (
      .clock       (clock),
      .reset       (reset),
      .done        (done),
      .tasta       (tasta),
      .active_zone (active_zone),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .p2_enable   (p2_enable),
      .ctrl_ack    (ctrl_ack),
      .p1_left     (p1_left),
      .p1_right    (p1_right),
      .p2_left     (p2_left),
      .p2_right    (p2_right),
      .ctrl_valid  (ctrl_valid),
      .ctrl_code   (ctrl_code),
      .held        (held)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      tasta = b;
      done  = 1'b1;
      @(negedge clock);
      done  = 1'b0;
      @(negedge clock);
   endtask

   // One frame tick; exp is the pulse vector the tick must produce.
   task automatic frame_tick(input logic [3:0] exp);
      if (exp != 4'b0000) move_q.push_back({tick_no[31:0], exp});
      @(negedge clock);
      active_zone = 1'b1; x_pos = 10'd1; y_pos = 10'd1;
      @(negedge clock);
      active_zone = 1'b0; x_pos = 10'd0; y_pos = 10'd0;
      repeat (3) @(negedge clock);
      tick_no++;
   endtask

   // Frame tick whose tick cycle coincides with the capture of byte b.
   task automatic tick_with_byte(input logic [7:0] b);
      @(negedge clock);
      active_zone = 1'b1; x_pos = 10'd1; y_pos = 10'd1;
      @(negedge clock);
      active_zone = 1'b0; x_pos = 10'd0; y_pos = 10'd0;
      tasta = b;
      done  = 1'b1;
      @(negedge clock);
      done  = 1'b0;
      repeat (3) @(negedge clock);
      tick_no++;
   endtask

   // Pop and acknowledge every expected control command, then expect idle.
   task automatic drain_ctrl();
      while (ctrl_q.size() > 0) begin
         check_val("ctrl_valid", ctrl_valid, 1);
         check_val("ctrl_code", ctrl_code, ctrl_q.pop_front());
         @(negedge clock);
         ctrl_ack = 1'b1;
         @(negedge clock);
         ctrl_ack = 1'b0;
      end
      check_val("ctrl_idle", ctrl_valid, 0);
   endtask

   // Move-pulse monitor: every non-zero pulse vector consumes one entry.
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clock);
         if (reset && ({p2_right, p2_left, p1_right, p1_left} != 4'b0000)) begin
            if (move_q.size() == 0) begin
               check_val("move_unexpected", {tick_no[31:0], p2_right, p2_left, p1_right, p1_left}, 0);
            end else begin
               e = move_q.pop_front();
               check_val("move_pulse", {tick_no[31:0], p2_right, p2_left, p1_right, p1_left}, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      #1;
      check_val("rst_outputs", {p1_left, p1_right, p2_left, p2_right, ctrl_valid, ctrl_code, held}, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      // P1 left: first pulse, first delay, then repeat
      send_byte(8'h1C);
      check_val("held_p1l", held, 4'b0001);
      for (int i = 0; i < 12; i++) frame_tick((i == 0 || i == 8 || i == 11) ? 4'b0001 : 4'b0000);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check_val("held_rel", held, 4'b0000);
      repeat (3) frame_tick(4'b0000);

      // both P1 keys held: no pulses; releasing left lets right move
      send_byte(8'h23);
      send_byte(8'h1C);
      check_val("held_both", held, 4'b0011);
      repeat (5) frame_tick(4'b0000);
      send_byte(8'hF0);
      send_byte(8'h1C);
      frame_tick(4'b0010);
      send_byte(8'hF0);
      send_byte(8'h23);
      frame_tick(4'b0000);

      // control priority and ack handshake
      send_byte(8'h29);
      send_byte(8'h76);
      send_byte(8'h16);
      ctrl_q.push_back(2'b00);
      ctrl_q.push_back(2'b01);
      ctrl_q.push_back(2'b10);
      drain_ctrl();
      // typematic re-make of a held control key does not re-arm it
      send_byte(8'h29);
      check_val("ctrl_typematic", ctrl_valid, 0);
      send_byte(8'hF0);
      send_byte(8'h29);
      send_byte(8'h1E);
      send_byte(8'h29);
      ctrl_q.push_back(2'b01);
      ctrl_q.push_back(2'b11);
      drain_ctrl();
      foreach (ctrl_q[i]) ctrl_q.delete(i);
      send_byte(8'hF0); send_byte(8'h29);
      send_byte(8'hF0); send_byte(8'h76);
      send_byte(8'hF0); send_byte(8'h16);
      send_byte(8'hF0); send_byte(8'h1E);

      // player 2 disabled, then enabled
      p2_enable = 1'b0;
      send_byte(8'h3B);
      check_val("held_p2l", held, 4'b0100);
      repeat (4) frame_tick(4'b0000);
      p2_enable = 1'b1;
      frame_tick(4'b0100);
      send_byte(8'hF0);
      send_byte(8'h3B);
      check_val("held_p2_rel", held, 4'b0000);
      frame_tick(4'b0000);

      // capture in the tick cycle, then reset mid-hold
      tick_with_byte(8'h1C);
      check_val("held_same_cyc", held, 4'b0001);
      frame_tick(4'b0001);
      send_byte(8'h29);
      check_val("ctrl_before_rst", ctrl_valid, 1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_val("rst_mid_hold", {p1_left, p1_right, p2_left, p2_right, ctrl_valid, ctrl_code, held}, 0);
      @(negedge clock);
      reset = 1'b1;
      frame_tick(4'b0000);

`ifdef ARROW_KEYS_EN
      send_byte(8'hE0);
      send_byte(8'h74);
      check_val("arrow_held", held, 4'b1000);
      frame_tick(4'b1000);
      send_byte(8'h4B);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h74);
      check_val("arrow_brk_keeps_plain", held, 4'b1000);
      send_byte(8'hF0);
      send_byte(8'h4B);
      check_val("arrow_all_rel", held, 4'b0000);
      frame_tick(4'b0000);
`else
      send_byte(8'hE0);
      send_byte(8'h74);
      check_val("ext_discard", held, 4'b0000);
      frame_tick(4'b0000);
      send_byte(8'h1C);
      check_val("parser_idle", held, 4'b0001);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check_val("ext_brk_discard", held, 4'b0001);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check_val("plain_brk", held, 4'b0000);
`endif

      repeat (4) @(negedge clock);
      check_val("sb_drain", move_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
